// File: rtl/viterbi_conv_encoder_if.sv
// Bit-in / symbol-out link of the rate-1/2 convolutional encoder.
// The master side supplies information bits; the slave side (the encoder)
// returns one 2-bit code symbol per accepted bit.
interface viterbi_conv_encoder_if;
  logic       bit_in;
  logic       bit_valid;
  logic [1:0] sym_out;
  logic       sym_valid;

  modport master (
    output bit_in,
    output bit_valid,
    input  sym_out,
    input  sym_valid
  );

  modport slave (
    input  bit_in,
    input  bit_valid,
    output sym_out,
    output sym_valid
  );
endinterface

// File: rtl/viterbi_conv_encoder.sv
// Rate-1/2 feed-forward convolutional encoder, constraint length K.
// Each accepted bit yields one registered symbol {y0,y1}, where each output
// is the parity of the K-bit window {history, current bit} masked by its
// generator polynomial. No backpressure: one symbol per accepted bit.
module viterbi_conv_encoder #(
  parameter int         K      = 3,
  parameter logic [7:0] G0_OCT = 8'o07,
  parameter logic [7:0] G1_OCT = 8'o05
) (
  input  logic                       clk,
  input  logic                       rst,
  viterbi_conv_encoder_if.slave      enc
);

  localparam int          M  = K - 1;
  localparam logic [K-1:0] G0 = G0_OCT[K-1:0];
  localparam logic [K-1:0] G1 = G1_OCT[K-1:0];

  // Parity of the encoder window under one generator mask.
  function automatic logic gen_parity(input logic [K-1:0] win,
                                      input logic [K-1:0] gen);
    return ^(win & gen);
  endfunction

  logic [M-1:0] st_p0;
  logic [1:0]   sym_p0;
  logic         vld_p0;
  logic [K-1:0] sr;

  // Window: history above, current input bit at position 0. Its low M bits
  // are also the next state (oldest bit drops out), which covers M=1 too.
  assign sr = {st_p0, enc.bit_in};

  // ---- stage p0: symbol register and shift state ----
  // Reset clears history and outputs; an accepted bit encodes and shifts in.
  always_ff @(posedge clk) begin
    if (rst) begin
      st_p0  <= '0;
      sym_p0 <= 2'b00;
      vld_p0 <= 1'b0;
    end else if (enc.bit_valid) begin
      sym_p0 <= {gen_parity(sr, G0), gen_parity(sr, G1)};
      vld_p0 <= 1'b1;
      st_p0  <= sr[M-1:0];
    end else begin
      vld_p0 <= 1'b0;
    end
  end

  assign enc.sym_out   = sym_p0;
  assign enc.sym_valid = vld_p0;

endmodule

// File: tb/tb_viterbi_conv_encoder.sv
// Scoreboard bench for viterbi_conv_encoder (K=3, G0=7, G1=5).
// The driver pushes the expected symbol and its due cycle for every bit it
// issues; the monitor pops on each sym_valid and checks value and timing.
module tb_viterbi_conv_encoder;

  typedef struct {
    logic [1:0] sym;
    int         cyc;
    string      name;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  viterbi_conv_encoder_if bus();

  viterbi_conv_encoder #(
    .K      (3),
    .G0_OCT (8'o07),
    .G1_OCT (8'o05)
  ) dut (
    .clk (clk),
    .rst (rst),
    .enc (bus.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Independent reference: window {st,b}, y0 = parity(win&111), y1 = parity(win&101).
  function automatic logic [1:0] ref_sym(input logic [1:0] st, input logic b);
    logic [2:0] w;
    w = {st, b};
    return {w[2] ^ w[1] ^ w[0], w[2] ^ w[0]};
  endfunction

  // Monitor: compare every presented symbol against the scoreboard head.
  always @(negedge clk) begin
    exp_t e;
    if (bus.sym_valid === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL spurious_sym_valid cycle=%0d got sym=%b, expected no symbol", cyc, bus.sym_out);
      end else begin
        e = sb.pop_front();
        if (bus.sym_out !== e.sym) begin
          errors++;
          $display("FAIL %s sym got=%b expected=%b", e.name, bus.sym_out, e.sym);
        end
        checks++;
        if (cyc != e.cyc) begin
          errors++;
          $display("FAIL %s_latency got cycle=%0d expected cycle=%0d", e.name, cyc, e.cyc);
        end
      end
    end else if (sb.size() != 0 && sb[0].cyc <= cyc) begin
      checks++;
      errors++;
      $display("FAIL %s_missing cycle=%0d sym_valid=%b expected symbol %b", sb[0].name, cyc, bus.sym_valid, sb[0].sym);
      void'(sb.pop_front());
    end
  end

  task automatic send_bit(input logic b, input logic [1:0] exp_sym, input string name);
    exp_t e;
    @(posedge clk); #1;
    rst = 1'b0;
    bus.bit_valid = 1'b1;
    bus.bit_in = b;
    e.sym = exp_sym;
    e.cyc = cyc + 1;
    e.name = name;
    sb.push_back(e);
  endtask

  task automatic idle(input int n, input logic junk);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      rst = 1'b0;
      bus.bit_valid = 1'b0;
      bus.bit_in = junk;
    end
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    while (sb.size() != 0 && budget < 20) begin
      @(posedge clk);
      budget++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout pending=%0d expected=0", sb.size());
      sb.delete();
    end
  endtask

  // Reset with a valid bit present: reset must win.
  task automatic do_reset(input string name);
    @(posedge clk); #1;
    rst = 1'b1;
    bus.bit_valid = 1'b1;
    bus.bit_in = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus.sym_out !== 2'b00 || bus.sym_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s got sym=%b vld=%b expected sym=00 vld=0", name, bus.sym_out, bus.sym_valid);
    end
    rst = 1'b0;
    bus.bit_valid = 1'b0;
  endtask

  logic [1:0] t1 [4] = '{2'b00, 2'b00, 2'b00, 2'b00};
  logic [1:0] t2 [4] = '{2'b11, 2'b01, 2'b10, 2'b10};
  logic       b3 [7] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
  logic [1:0] t3 [7] = '{2'b11, 2'b10, 2'b00, 2'b01, 2'b01, 2'b11, 2'b00};

  initial begin
    logic [9:0] pat;
    logic [1:0] mst;
    bus.bit_in = 1'b0;
    bus.bit_valid = 1'b0;

    do_reset("reset_initial");

    // Test 1: all-zero input
    for (int i = 0; i < 4; i++) send_bit(1'b0, t1[i], $sformatf("zeros_%0d", i));
    idle(1, 1'b0);
    drain();

    // Test 2: all-one input
    do_reset("reset_t2");
    for (int i = 0; i < 4; i++) send_bit(1'b1, t2[i], $sformatf("ones_%0d", i));
    idle(1, 1'b1);
    drain();

    // Test 3: 1,0,1,1,0 plus two tail zeros
    do_reset("reset_t3");
    for (int i = 0; i < 7; i++) send_bit(b3[i], t3[i], $sformatf("tail_%0d", i));
    idle(1, 1'b0);
    drain();

    // Test 4: single pulse surrounded by idle cycles; junk bit_in while idle
    do_reset("reset_t4");
    idle(3, 1'b1);
    send_bit(1'b1, 2'b11, "pulse");
    idle(3, 1'b1);
    drain();
    checks++;
    if (bus.sym_out !== 2'b11 || bus.sym_valid !== 1'b0) begin
      errors++;
      $display("FAIL pulse_hold got sym=%b vld=%b expected sym=11 vld=0", bus.sym_out, bus.sym_valid);
    end
    // State must also have held through idle: next bit 0 sees state 01
    send_bit(1'b0, 2'b10, "after_idle");
    idle(1, 1'b0);
    drain();

    // Test 5: continuous burst checked against the reference model
    do_reset("reset_t5");
    pat = 10'b1011001101;
    mst = 2'b00;
    for (int i = 0; i < 10; i++) begin
      send_bit(pat[i], ref_sym(mst, pat[i]), $sformatf("burst_%0d", i));
      mst = {mst[0], pat[i]};
    end
    idle(1, 1'b0);
    drain();

    // Test 6: reset in state 11, then encode from zero state
    do_reset("reset_t6");
    send_bit(1'b1, 2'b11, "pre_rst_0");
    send_bit(1'b1, 2'b01, "pre_rst_1");
    do_reset("reset_midstream");
    send_bit(1'b1, 2'b11, "post_rst");
    idle(2, 1'b0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL global_timeout reached at %0t expected completion", $time);
    $fatal(1, "timeout");
  end

endmodule
